// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier issue controller: op encoding,
// operand/product widths and the raw-op decoder.
package mul_pkg;

  localparam int MUL_OPW = 3;
  localparam int XLEN    = 64;
  localparam int OPND_W  = 66;
  localparam int PROD_W  = 132;

  typedef enum logic [MUL_OPW-1:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_MULW   = 3'd4
  } mul_op_e;

  // Reserved encodings 5-7 fold onto MUL so downstream logic only ever
  // sees the five legal ops.
  function automatic mul_op_e decode_op(input logic [MUL_OPW-1:0] raw);
    mul_op_e op;
    case (raw)
      3'd1:    op = OP_MULH;
      3'd2:    op = OP_MULHSU;
      3'd3:    op = OP_MULHU;
      3'd4:    op = OP_MULW;
      default: op = OP_MUL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mul_ext.sv
// Operand extension: widens both 64-bit sources to 66 bits so a single
// signed 66x66 datapath covers signed, unsigned and mixed multiplies.
module mul_ext
  import mul_pkg::*;
(
  input  mul_op_e           op,
  input  logic [XLEN-1:0]   src1,
  input  logic [XLEN-1:0]   src2,
  output logic [OPND_W-1:0] x,
  output logic [OPND_W-1:0] y
);

  // Sign extension is the common case; unsigned/word ops override it.
  always_comb begin
    x = {{2{src1[63]}}, src1};
    y = {{2{src2[63]}}, src2};
    case (op)
      OP_MULHSU: y = {2'b00, src2};
      OP_MULHU: begin
        x = {2'b00, src1};
        y = {2'b00, src2};
      end
      OP_MULW: begin
        x = {{34{src1[31]}}, src1[31:0]};
        y = {{34{src2[31]}}, src2[31:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mul_ctrl.sv
// Issue-side controller for the pipelined radix-4 Booth multiplier.
// Registers extended operands into the datapath, tracks valid/op/tag for
// each datapath stage, and formats the 64-bit result from the product.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and payload until it transfers;
// in_ready here is !out_valid | out_ready, so it depends combinationally on
// out_ready but never on in_valid. out_valid/out_data/out_tag stay stable
// while out_valid & !out_ready. flush (and reset) drop outstanding results
// without a transfer.
module mul_ctrl
  import mul_pkg::*;
#(
  parameter int LAT  = 2,
  parameter int TAGW = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MUL_OPW-1:0] in_op,
  input  logic [XLEN-1:0]    in_src1,
  input  logic [XLEN-1:0]    in_src2,
  input  logic [TAGW-1:0]    in_tag,
  output logic [OPND_W-1:0]  dp_x,
  output logic [OPND_W-1:0]  dp_y,
  output logic               dp_en,
  input  logic [PROD_W-1:0]  dp_prod,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_data,
  output logic [TAGW-1:0]    out_tag
);

  logic              advance;
  logic              accept;
  mul_op_e           in_op_dec;
  logic [OPND_W-1:0] ext_x;
  logic [OPND_W-1:0] ext_y;
  logic [XLEN-1:0]   fmt_data;
  logic              unused_prod_hi;

  logic [LAT-1:0]    stg_v;
  mul_op_e           stg_op  [LAT];
  logic [TAGW-1:0]   stg_tag [LAT];

  // The whole pipe moves as one; a held result freezes every stage.
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign dp_en     = advance;
  assign accept    = in_valid && advance;
  assign in_op_dec = decode_op(in_op);

  mul_ext u_ext (
    .op   (in_op_dec),
    .src1 (in_src1),
    .src2 (in_src2),
    .x    (ext_x),
    .y    (ext_y)
  );

  // Result selection for the op currently at the datapath output.
  always_comb begin
    fmt_data = dp_prod[63:0];
    case (stg_op[LAT-1])
      OP_MULH, OP_MULHSU, OP_MULHU: fmt_data = dp_prod[127:64];
      OP_MULW:                      fmt_data = {{32{dp_prod[31]}}, dp_prod[31:0]};
      default: ;
    endcase
  end

  // Top product bits only carry sign and are never selected.
  assign unused_prod_hi = ^dp_prod[PROD_W-1:128];

  // Valid bits: flush wins over advance; bubbles travel like ops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stg_v     <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      stg_v     <= '0;
      out_valid <= 1'b0;
    end else if (advance) begin
      stg_v[0] <= in_valid;
      for (int i = 1; i < LAT; i++) begin
        stg_v[i] <= stg_v[i-1];
      end
      out_valid <= stg_v[LAT-1];
    end
  end

  // Payload: operands/op/tag load on accept and shift on advance; the
  // output payload is held across a flush so it never glitches.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dp_x     <= '0;
      dp_y     <= '0;
      out_data <= '0;
      out_tag  <= '0;
      for (int i = 0; i < LAT; i++) begin
        stg_op[i]  <= OP_MUL;
        stg_tag[i] <= '0;
      end
    end else if (advance) begin
      if (accept) begin
        dp_x       <= ext_x;
        dp_y       <= ext_y;
        stg_op[0]  <= in_op_dec;
        stg_tag[0] <= in_tag;
      end
      for (int i = 1; i < LAT; i++) begin
        stg_op[i]  <= stg_op[i-1];
        stg_tag[i] <= stg_tag[i-1];
      end
      if (!flush) begin
        out_data <= fmt_data;
        out_tag  <= stg_tag[LAT-1];
      end
    end
  end

endmodule

// File: tb/tb_mul_ctrl.sv
// Self-checking bench for mul_ctrl with a behavioural stand-in for the
// multiplier datapath and a tag+data scoreboard.
module tb_mul_ctrl;

  localparam int LAT  = 2;
  localparam int TAGW = 6;
  localparam int W    = 64 + TAGW;

  logic            clock = 1'b0;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op;
  logic [63:0]     in_src1;
  logic [63:0]     in_src2;
  logic [TAGW-1:0] in_tag;
  logic [65:0]     dp_x;
  logic [65:0]     dp_y;
  logic            dp_en;
  logic [131:0]    dp_prod;
  logic            out_valid;
  logic            out_ready;
  logic [63:0]     out_data;
  logic [TAGW-1:0] out_tag;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  bit rand_rdy = 1'b0;

  mul_ctrl #(.LAT(LAT), .TAGW(TAGW)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_src1   (in_src1),
    .in_src2   (in_src2),
    .in_tag    (in_tag),
    .dp_x      (dp_x),
    .dp_y      (dp_y),
    .dp_en     (dp_en),
    .dp_prod   (dp_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end

  // ---------------- datapath stand-in ----------------
  // Signed 66x66 product; one register here plus dp_x/dp_y gives LAT=2.
  logic [131:0] prod_now;
  logic [131:0] dp_pipe;
  assign prod_now = {{66{dp_x[65]}}, dp_x} * {{66{dp_y[65]}}, dp_y};
  always_ff @(posedge clock) begin
    if (reset) dp_pipe <= '0;
    else if (dp_en) dp_pipe <= prod_now;
  end
  assign dp_prod = dp_pipe;

  // ---------------- golden model ----------------
  function automatic logic [63:0] golden(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [129:0] ea, eb, p;
    logic [63:0]  lo;
    logic [31:0]  w;
    ea = {{66{a[63]}}, a};
    eb = {{66{b[63]}}, b};
    case (op)
      3'd1: begin p = ea * eb; return p[127:64]; end
      3'd2: begin eb = {66'b0, b}; p = ea * eb; return p[127:64]; end
      3'd3: begin ea = {66'b0, a}; eb = {66'b0, b}; p = ea * eb; return p[127:64]; end
      3'd4: begin w = a[31:0] * b[31:0]; return {{32{w[31]}}, w}; end
      default: begin lo = a * b; return lo; end
    endcase
  endfunction

  function automatic logic [63:0] rand64();
    case ($urandom_range(0, 6))
      0: return '1;
      1: return '0;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      4: return {$urandom, 32'h8000_0000};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: retire on handshake, check hold while stalled and
  // the ready relation every cycle.
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_out;
  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      check("in_ready_dp_en", W'({in_ready, dp_en}), W'({2{!out_valid || out_ready}}));
      if (prev_stall && out_valid)
        check("stall_hold", {out_tag, out_data}, prev_out);
      if (out_valid && out_ready && !flush) begin
        check("result_expected", W'(exp_q.size() > 0), W'(1));
        if (exp_q.size() > 0) check("result", {out_tag, out_data}, exp_q.pop_front());
      end
      prev_stall = out_valid && !out_ready && !flush;
      prev_out   = {out_tag, out_data};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [TAGW-1:0] tag, input logic [63:0] exp, input bit keep);
    int waits = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_src1  = a;
    in_src2  = b;
    in_tag   = tag;
    @(negedge clock);
    while (!in_ready && waits < 200) begin
      @(negedge clock);
      waits++;
    end
    if (in_ready) begin
      if (keep) exp_q.push_back({tag, exp});
    end else begin
      check("accept_timeout", W'(in_ready), W'(1));
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    while ((exp_q.size() != 0 || out_valid) && c < 500) begin
      @(posedge clock);
      #1;
      c++;
    end
    check("drain", W'(exp_q.size()), W'(0));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0;
    in_src1 = '0; in_src2 = '0; in_tag = '0; out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_in_ready",  W'(in_ready),  W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_out_data",  W'(out_data),  W'(0));
    check("rst_out_tag",   W'(out_tag),   W'(0));
    check("rst_dp_x",      W'(dp_x),      W'(0));
    check("rst_dp_y",      W'(dp_y),      W'(0));
    check("rst_dp_en",     W'(dp_en),     W'(1));
    reset = 1'b0;
    @(posedge clock);
    #1;

    // MUL -1 x 2, latency measured from the accepting edge
    begin
      int n = 0;
      send(3'd0, '1, 64'd2, 6'h15, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
      do begin
        @(negedge clock);
        n++;
      end while (!out_valid && n < 20);
      check("latency", W'(n), W'(LAT + 1));
    end
    drain();

    // High-half variants, word op with garbage upper bits, reserved op
    send(3'd1, '1, '1, 6'd1, 64'h0, 1'b1);
    send(3'd2, '1, '1, 6'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    send(3'd3, '1, '1, 6'd3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    send(3'd4, 64'hDEAD_BEEF_8000_0000, 64'h1234_5678_0000_0001, 6'd4, 64'hFFFF_FFFF_8000_0000, 1'b1);
    send(3'd7, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 6'd5, 64'hFFFF_FFFF_FFFF_FFF1, 1'b1);
    drain();

    // 8 back-to-back ops with out_ready low for cycles 3-6
    fork
      begin
        repeat (3) @(posedge clock);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clock);
        #1 out_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 8; i++)
      send(3'd0, 64'(i + 1), 64'h100, TAGW'(i + 8), 64'((i + 1) * 256), 1'b1);
    drain();

    // Flush with three ops in flight plus one accepted in the flush cycle
    send(3'd0, 64'd11, 64'd1, 6'd20, 64'd0, 1'b0);
    send(3'd0, 64'd12, 64'd1, 6'd21, 64'd0, 1'b0);
    send(3'd0, 64'd13, 64'd1, 6'd22, 64'd0, 1'b0);
    in_valid = 1'b1; in_op = 3'd0; in_src1 = 64'd99; in_src2 = 64'd1; in_tag = 6'd23;
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", W'(out_valid), W'(0));
    repeat (4) begin
      @(posedge clock);
      #1;
      check("flush_quiet", W'(out_valid), W'(0));
    end
    send(3'd0, 64'd7, 64'd6, 6'd24, 64'd42, 1'b1);
    drain();

    // Reset while a result is held by backpressure
    out_ready = 1'b0;
    send(3'd3, '1, 64'd2, 6'd25, 64'd1, 1'b1);
    begin
      int c = 0;
      while (!out_valid && c < 50) begin
        @(negedge clock);
        c++;
      end
    end
    check("stalled_valid", W'(out_valid), W'(1));
    #1 reset = 1'b1;
    #1;
    check("async_rst_out_valid", W'(out_valid), W'(0));
    check("async_rst_in_ready",  W'(in_ready),  W'(1));
    check("async_rst_out_tag",   W'(out_tag),   W'(0));
    exp_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clock);
      #1;
      check("post_rst_quiet", W'(out_valid), W'(0));
    end

    // Random ops against the golden model with random backpressure
    rand_rdy = 1'b1;
    for (int k = 0; k < 10000; k++) begin
      logic [2:0]  op;
      logic [63:0] a, b;
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clock);
        #1;
      end
      op = 3'($urandom_range(0, 7));
      a  = rand64();
      b  = rand64();
      send(op, a, b, TAGW'($urandom), golden(op, a, b), 1'b1);
    end
    rand_rdy = 1'b0;
    @(posedge clock);
    #2 out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Random out_ready pattern while the random phase runs
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

endmodule
